// File: rtl/demux_4x1_dispatcher_if.sv
// Bundle of the upstream valid/ready port, the four downstream channel
// ports and the status outputs of demux_4x1_dispatcher.
//   slave  : the dispatcher itself
//   master : the surrounding producer/consumer environment
interface demux_4x1_dispatcher_if #(
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0]   data_in_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [4*DATA_W-1:0] data_out_o;
    logic [3:0]          valid_out_o;
    logic [3:0]          out_ready_i;
    logic [1:0]          sel_o;
    logic                busy_o;
    logic                drop_o;

    modport slave (
        input  data_in_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output data_out_o,
        output valid_out_o,
        output sel_o,
        output busy_o,
        output drop_o
    );

    modport master (
        output data_in_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  data_out_o,
        input  valid_out_o,
        input  sel_o,
        input  busy_o,
        input  drop_o
    );
endinterface

// File: rtl/demux_4x1_dispatcher.sv
// demux_4x1_dispatcher: takes one word at a time from an upstream
// valid/ready source, picks a ready downstream channel round-robin and
// presents the word on that channel's slice until it is taken.
// Optional feature macro: DEMUX_DISPATCH_TIMEOUT_EN -- when defined, a held
// word that has waited TIMEOUT cycles without a transfer is dropped and
// drop_o pulses for one cycle. Without it the block waits indefinitely and
// drop_o is constant 0.
module demux_4x1_dispatcher #(
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    demux_4x1_dispatcher_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } state_t;

    // The wait counter is 8 bits wide, so TIMEOUT has to stay within 2..255.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("demux_4x1_dispatcher: TIMEOUT must be in 2..255");
    end

    state_t              state_reg, state_next;
    logic [1:0]          ptr_reg, ptr_next;
    logic [1:0]          sel_reg, sel_next;
    logic [DATA_W-1:0]   hold_reg, hold_next;
    logic [3:0]          valid_reg, valid_next;
    logic [4*DATA_W-1:0] data_reg, data_next;
    logic                in_ready_reg, in_ready_next;
    logic                busy_reg, busy_next;
    logic                drop_reg, drop_next;

    logic [1:0]          cand_idx [4];
    logic [3:0]          cand_rdy;
    logic                grant_found;
    logic [1:0]          grant_idx;
    logic [3:0]          sel_onehot;
    logic [4*DATA_W-1:0] data_fill;
    logic                transfer;
    logic                timeout_hit;

    // Per-channel helpers: candidate order for the round-robin scan
    // (ptr, ptr+1, ptr+2, ptr+3 mod 4), plus the valid/data pattern that
    // puts the held word on the selected channel only.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign cand_idx[gi] = ptr_reg + 2'(gi);
        assign cand_rdy[gi] = bus.out_ready_i[cand_idx[gi]];
        assign sel_onehot[gi] = (sel_reg == 2'(gi));
        assign data_fill[gi*DATA_W +: DATA_W] = sel_onehot[gi] ? hold_reg : '0;
    end

    // Pick the first ready channel in scan order; lowest offset wins.
    always_comb begin
        grant_found = |cand_rdy;
        grant_idx   = cand_idx[0];
        for (int i = 3; i >= 0; i--) begin
            if (cand_rdy[i]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

    // A transfer needs the registered valid to be up already, so the first
    // SEND cycle (valid still rising) can never complete a transfer.
    assign transfer = (state_reg == SEND) && valid_reg[sel_reg] && bus.out_ready_i[sel_reg];

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_reg, wait_cnt_next;

    // A transfer on the limit cycle wins over the drop.
    assign timeout_hit = (state_reg != IDLE) && !transfer && (wait_cnt_reg == CNT_LIMIT);

    // Wait counter: held at zero while idle (so it starts from zero on
    // every accept) and counts every held cycle that does not transfer.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (state_reg == IDLE) begin
            wait_cnt_next = '0;
        end else if (!transfer && !timeout_hit) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
        end
    end
`else
    // No timeout: drop_next is never set, so drop_o reduces to constant 0.
    assign timeout_hit = 1'b0;
`endif

    // Next-state and registered-output logic of the IDLE/GRANT/SEND FSM.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        hold_next  = hold_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        drop_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.in_valid_i && in_ready_reg) begin
                    hold_next  = bus.data_in_i;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (timeout_hit) begin
                    // Pointer untouched: no channel was ever granted.
                    state_next = IDLE;
                    drop_next  = 1'b1;
                end else if (grant_found) begin
                    sel_next   = grant_idx;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (transfer || timeout_hit) begin
                    valid_next = '0;
                    data_next  = '0;
                    ptr_next   = sel_reg + 2'd1;
                    drop_next  = timeout_hit;
                    state_next = IDLE;
                end else begin
                    // Hold valid and data stable even if the consumer
                    // withdraws ready; no re-grant from here.
                    valid_next = sel_onehot;
                    data_next  = data_fill;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = '0;
                data_next  = '0;
            end
        endcase

        in_ready_next = (state_next == IDLE);
        busy_next     = (state_next != IDLE);
    end

    // State and output registers; reset drops any held word silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            sel_reg      <= '0;
            hold_reg     <= '0;
            valid_reg    <= '0;
            data_reg     <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            drop_reg     <= 1'b0;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            hold_reg     <= hold_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            in_ready_reg <= in_ready_next;
            busy_reg     <= busy_next;
            drop_reg     <= drop_next;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
            wait_cnt_reg <= wait_cnt_next;
`endif
        end
    end

    assign bus.in_ready_o  = in_ready_reg;
    assign bus.data_out_o  = data_reg;
    assign bus.valid_out_o = valid_reg;
    assign bus.sel_o       = sel_reg;
    assign bus.busy_o      = busy_reg;
    assign bus.drop_o      = drop_reg;
endmodule

// File: tb/tb_demux_4x1_dispatcher.sv
// Testbench for demux_4x1_dispatcher. Accepted words are pushed to a
// scoreboard with their expected channel; a negedge monitor pops and
// compares whenever a channel transfer is about to happen. Timeout
// scenarios run only when DEMUX_DISPATCH_TIMEOUT_EN is defined.
module tb_demux_4x1_dispatcher;
    localparam int DW = 8;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 16;
`endif

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    int   pushed = 0;
    int   drops = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    demux_4x1_dispatcher_if #(.DATA_W(DW)) bus ();

    demux_4x1_dispatcher #(
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Monitor: a transfer happens at the next rising edge when the valid
    // channel also sees ready; compare it against the scoreboard head.
    int              mon_ch;
    exp_t            mon_e;
    logic [4*DW-1:0] mon_vec;
    always @(negedge clk) begin
        if (bus.valid_out_o != 4'b0000) begin
            mon_ch = 0;
            for (int i = 0; i < 4; i++) begin
                if (bus.valid_out_o[i]) mon_ch = i;
            end
            if (bus.out_ready_i[mon_ch]) begin
                delivered++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: delivery on ch %0d data %h, required none", mon_ch, bus.data_out_o);
                end else begin
                    mon_e = sb.pop_front();
                    mon_vec = '0;
                    mon_vec[mon_e.ch*DW +: DW] = mon_e.data;
                    if (bus.valid_out_o !== (4'b0001 << mon_e.ch) || bus.data_out_o !== mon_vec) begin
                        errors++;
                        $display("FAIL sb_delivery: valid %b data %h, required valid %b data %h",
                                 bus.valid_out_o, bus.data_out_o, 4'b0001 << mon_e.ch, mon_vec);
                    end else begin
                        $display("deliver ch=%0d data=%h", mon_e.ch, mon_e.data);
                    end
                end
            end
        end
        if (bus.drop_o === 1'b1) begin
            drops++;
            $display("drop observed at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word; exp_ch < 0 means the word is not expected to arrive.
    task automatic accept(input logic [DW-1:0] d, input int exp_ch);
        int n;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready_o %b, required 1", bus.in_ready_o);
        end
        bus.data_in_i  = d;
        bus.in_valid_i = 1'b1;
        if (exp_ch >= 0) begin
            sb.push_back('{ch: exp_ch, data: d});
            pushed++;
        end
        tick();
        bus.in_valid_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL accept_busy: busy %b in_ready %b, required 1 0", bus.busy_o, bus.in_ready_o);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: busy %b after %0d cycles, required 0", bus.busy_o, n);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus.in_ready_o, bus.busy_o, bus.drop_o, bus.sel_o, bus.valid_out_o, bus.data_out_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy %b busy %b drop %b sel %0d valid %b data %h, required all 0",
                     bus.in_ready_o, bus.busy_o, bus.drop_o, bus.sel_o, bus.valid_out_o, bus.data_out_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.sel_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: rdy %b busy %b sel %0d, required 1 0 0", bus.in_ready_o, bus.busy_o, bus.sel_o);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_valid;
        bus.out_ready_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            accept(8'hA0 + 8'(i), i % 4);
            tick();
            checks++;
            if (bus.sel_o !== 2'(i % 4) || bus.valid_out_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_grant: sel %0d valid %b, required %0d 0000", bus.sel_o, bus.valid_out_o, i % 4);
            end
            tick();
            exp_valid = 4'b0001 << (i % 4);
            checks++;
            if (bus.valid_out_o !== exp_valid) begin
                errors++;
                $display("FAIL rr_valid: valid %b, required %b", bus.valid_out_o, exp_valid);
            end
            tick();
            checks++;
            if (bus.in_ready_o !== 1'b1 || bus.valid_out_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_done: rdy %b valid %b, required 1 0000", bus.in_ready_o, bus.valid_out_o);
            end
        end
    endtask

    task automatic test_skip_busy();
        // pointer is 1 here
        bus.out_ready_i = 4'b1001;
        accept(8'h31, 3);
        tick();
        checks++;
        if (bus.sel_o !== 2'd3) begin
            errors++;
            $display("FAIL skip_sel3: sel %0d, required 3", bus.sel_o);
        end
        wait_idle();
        accept(8'h32, 0);
        tick();
        checks++;
        if (bus.sel_o !== 2'd0) begin
            errors++;
            $display("FAIL skip_sel0: sel %0d, required 0", bus.sel_o);
        end
        wait_idle();
    endtask

    task automatic test_stall();
        logic [4*DW-1:0] exp_vec;
        exp_vec = '0;
        exp_vec[2*DW +: DW] = 8'hC3;
        bus.out_ready_i = 4'b0100;
        accept(8'hC3, 2);
        tick();
        // consumer withdraws; upstream pushes junk that must be ignored
        bus.out_ready_i = 4'b0000;
        bus.data_in_i   = 8'h5A;
        bus.in_valid_i  = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.valid_out_o !== 4'b0100 || bus.data_out_o !== exp_vec || bus.sel_o !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid %b data %h sel %0d, required 0100 %h 2",
                         c, bus.valid_out_o, bus.data_out_o, bus.sel_o, exp_vec);
            end
            tick();
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 4'b0100;
        tick();
        checks++;
        if (bus.valid_out_o !== 4'b0000 || bus.data_out_o !== '0 || bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: valid %b data %h rdy %b busy %b, required 0000 0 1 0",
                     bus.valid_out_o, bus.data_out_o, bus.in_ready_o, bus.busy_o);
        end
    endtask

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        // pointer is 3 here
        bus.out_ready_i = 4'b0000;
        accept(8'hEE, -1);
        for (int c = 1; c <= TO; c++) begin
            tick();
            checks++;
            if (c == TO) begin
                if (bus.drop_o !== 1'b1 || bus.in_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.valid_out_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL timeout_drop: drop %b rdy %b busy %b valid %b, required 1 1 0 0000",
                             bus.drop_o, bus.in_ready_o, bus.busy_o, bus.valid_out_o);
                end
            end else if (bus.drop_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.valid_out_o !== 4'b0000) begin
                errors++;
                $display("FAIL timeout_wait: cycle %0d drop %b busy %b valid %b, required 0 1 0000",
                         c, bus.drop_o, bus.busy_o, bus.valid_out_o);
            end
        end
        tick();
        checks++;
        if (bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: drop %b one cycle later, required 0", bus.drop_o);
        end
        // pointer must still be 3
        bus.out_ready_i = 4'b1111;
        accept(8'h77, 3);
        wait_idle();
    endtask

    task automatic test_coincide();
        // pointer is 0 here
        bus.out_ready_i = 4'b0001;
        accept(8'h99, 0);
        tick();
        bus.out_ready_i = 4'b0000;
        for (int c = 2; c < TO; c++) begin
            tick();
            checks++;
            if (bus.drop_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL coincide_wait: cycle %0d drop %b busy %b, required 0 1", c, bus.drop_o, bus.busy_o);
            end
        end
        bus.out_ready_i = 4'b0001;
        tick();
        checks++;
        if (bus.drop_o !== 1'b0 || bus.valid_out_o !== 4'b0000 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL coincide_deliver: drop %b valid %b rdy %b, required 0 0000 1",
                     bus.drop_o, bus.valid_out_o, bus.in_ready_o);
        end
    endtask
`endif

    task automatic test_reset_mid_send();
        bus.out_ready_i = 4'b0100;
        accept(8'h3C, -1);
        tick();
        bus.out_ready_i = 4'b0000;
        tick();
        checks++;
        if (bus.valid_out_o !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_setup: valid %b, required 0100", bus.valid_out_o);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready_o, bus.busy_o, bus.drop_o, bus.sel_o, bus.valid_out_o, bus.data_out_o} !== '0) begin
            errors++;
            $display("FAIL midrst_async: rdy %b busy %b drop %b sel %0d valid %b data %h, required all 0",
                     bus.in_ready_o, bus.busy_o, bus.drop_o, bus.sel_o, bus.valid_out_o, bus.data_out_o);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_ready_o !== 1'b1 || bus.sel_o !== 2'd0 || bus.drop_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: rdy %b sel %0d drop %b, required 1 0 0", bus.in_ready_o, bus.sel_o, bus.drop_o);
        end
        // pointer back to 0
        bus.out_ready_i = 4'b1111;
        accept(8'h42, 0);
        wait_idle();
    endtask

    initial begin
        bus.data_in_i   = '0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 4'b0000;

        test_reset();
        test_round_robin();
        test_skip_busy();
        test_stall();
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        test_timeout();
        test_coincide();
`endif
        test_reset_mid_send();
        tick();

        checks++;
        if (sb.size() != 0 || delivered != pushed) begin
            errors++;
            $display("FAIL sb_final: %0d pending, %0d delivered, required 0 pending, %0d delivered",
                     sb.size(), delivered, pushed);
        end
        checks++;
`ifdef DEMUX_DISPATCH_TIMEOUT_EN
        if (drops != 1) begin
`else
        if (drops != 0) begin
`endif
            errors++;
            $display("FAIL drop_count: %0d drops seen", drops);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_4x1_dispatcher.md
# demux_4x1_dispatcher

Sequencing controller for the 1-to-4 demultiplexer datapath. Accepts words from a single upstream valid/ready source, picks a destination channel round-robin among downstream channels that are ready, and drives the demux select and per-channel valid. Words that cannot be delivered within a bounded wait are dropped and flagged. Sits between the upstream producer and four downstream consumers, and replaces a static select input.

## Interface
- DATA_W, 1: width of one data word.
- TIMEOUT, 16: cycles a held word may wait before it is dropped; legal range 2..255.

- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_in_i  input  DATA_W  upstream word.
- in_valid_i  input  1  upstream word valid.
- in_ready_o  output  1  dispatcher can accept a word.
- data_out_o  output  4*DATA_W  channel k uses slice [k*DATA_W +: DATA_W].
- valid_out_o  output  4  per-channel valid; one-hot or zero.
- out_ready_i  input  4  per-channel downstream ready.
- sel_o  output  2  current or last granted channel (demux select).
- busy_o  output  1  a word is held (state is not IDLE).
- drop_o  output  1  one-cycle pulse when a held word is discarded.

## Operation
- All outputs are registered. Reset values: in_ready_o=0, data_out_o=0, valid_out_o=0, sel_o=0, busy_o=0, drop_o=0. State is IDLE, the round-robin pointer is 0, and the wait counter is 0.
- FSM states are IDLE, GRANT and SEND.
- IDLE: in_ready_o=1.
  - On in_valid_i & in_ready_o, capture data_in_i into the hold register, clear the wait counter and go to GRANT.
  - in_ready_o is 0 in every state other than IDLE.
- GRANT: scan out_ready_i starting at the pointer, in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the first ready channel k: set sel_o=k and go to SEND.
  - If no channel is ready, stay in GRANT and increment the wait counter.
- SEND:
  - Drive valid_out_o[sel_o]=1.
  - Drive the held word on the sel_o slice of data_out_o; all other slices are 0.
  - Transfer occurs when valid_out_o[sel_o] & out_ready_i[sel_o]. Then clear valid and data, set pointer = sel_o+1 (wraps 3→0), and go to IDLE.
  - valid_out_o stays asserted and the data stays stable until the transfer, even if out_ready_i drops. No re-grant happens from SEND.
- Wait counter: increments on every GRANT or SEND cycle without a transfer. Timeout handling is described under Configuration.
- Simultaneous events:
  - A transfer in the same cycle the counter reaches the limit counts as a delivery, not a drop.
  - Upstream in_valid_i while busy is ignored; no back-pressure beyond in_ready_o=0.
- Reset mid-operation: the held word is lost, all outputs return to their reset values immediately, and no drop_o is raised.

## Timing
- Word accepted at edge N.
  - GRANT decision at edge N+1, if some out_ready_i is high during cycle N+1.
  - valid_out_o is visible after edge N+2.
  - Earliest transfer is at edge N+3. in_ready_o is high after edge N+3.
  - Next accept is at edge N+4.
- Peak throughput is 1 word per 4 cycles.
- First in_ready_o=1 appears one edge after rst_i deasserts.
- drop_o is high for exactly one cycle, coincident with the return to IDLE.

## Configuration
- DEMUX_DISPATCH_TIMEOUT_EN defined:
  - When the wait counter reaches TIMEOUT-1 without a transfer, the next edge clears valid_out_o and data_out_o, pulses drop_o, and returns to IDLE with in_ready_o=1.
  - The pointer advances past sel_o if the drop happened in SEND, and is unchanged if it happened in GRANT.
- Not defined:
  - No counter and no drop. The block waits indefinitely in GRANT or SEND, and drop_o is tied to 0.

## Test plan
- Reset check: assert rst_i mid-SEND with valid_out_o=0100. Required: all outputs are 0 immediately; in_ready_o=1 one edge after release; sel_o=0.
- Round-robin: out_ready_i=1111, four words A, B, C, D. Required: delivered on channels 0, 1, 2, 3 in order; sel_o follows 0, 1, 2, 3; the fifth word goes to channel 0.
- Skip busy channels: pointer=1, out_ready_i=1001. Required: grant to channel 3 (sel_o=3); the next grant from pointer 0 goes to channel 0.
- Stall in SEND: grant channel 2, then out_ready_i[2]=0 for 5 cycles, then 1. Required: valid_out_o=0100 and the data are held stable for all 5 cycles; one transfer; then IDLE.
- Timeout (macro defined, TIMEOUT=4): out_ready_i=0000 after accept. Required: drop_o pulses on the 4th GRANT cycle; valid_out_o never asserts; pointer unchanged; in_ready_o=1 on the next cycle.
- Transfer and timeout coincide (macro defined): transfer occurs on the limit cycle. Required: delivery counted; drop_o=0.
